// File: rtl/rv32_x_ccm_pkg.sv
// Shared types for the closely-coupled memory ports: owner tags, request bundle and data width.
package rv32_x_ccm_pkg;

    localparam int CCM_DW = 32;
    localparam int CCM_SW = CCM_DW / 8;
    localparam int CCM_AW = 12;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        LSU  = 2'd1,
        DMA  = 2'd2
    } ccm_owner_e;

    typedef struct packed {
        logic              we;
        logic [CCM_AW-1:0] addr;
        logic [CCM_DW-1:0] wdata;
        logic [CCM_SW-1:0] wstrb;
    } ccm_req_t;

endpackage

// File: rtl/dccm_arb_wait_ctr.sv
// Saturating count of consecutive DMA refusals; raises force_dma once DMA has waited MAX_WAIT cycles.
module dccm_arb_wait_ctr
    import rv32_x_ccm_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dma_valid,
    input  logic dma_ready,
    input  logic both_valid,
    output logic force_dma
);

    logic [3:0] wait_cnt_r;

    // Count refused DMA cycles, restart whenever DMA is served or drops its request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 4'd0;
        end else if (!dma_valid || dma_ready) begin
            wait_cnt_r <= 4'd0;
        end else if (wait_cnt_r != 4'hF) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign force_dma = both_valid && (wait_cnt_r == 4'(MAX_WAIT));

endmodule

// File: rtl/dccm_port_arbiter.sv
// Single-port DCCM arbiter between LSU (priority) and DMA/debug, with one-cycle read return routing.
// Build macro DCCM_DMA_STARVE_GUARD_EN adds a wait counter that forces a DMA grant after MAX_WAIT refusals.
module dccm_port_arbiter
    import rv32_x_ccm_pkg::*;
#(
    parameter int AW       = CCM_AW,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_req_we,
    input  logic [AW-1:0]     lsu_req_addr,
    input  logic [CCM_DW-1:0] lsu_req_wdata,
    input  logic [CCM_SW-1:0] lsu_req_wstrb,
    output logic              lsu_rsp_valid,
    output logic [CCM_DW-1:0] lsu_rsp_rdata,
    input  logic              dma_req_valid,
    output logic              dma_req_ready,
    input  logic              dma_req_we,
    input  logic [AW-1:0]     dma_req_addr,
    input  logic [CCM_DW-1:0] dma_req_wdata,
    input  logic [CCM_SW-1:0] dma_req_wstrb,
    output logic              dma_rsp_valid,
    output logic [CCM_DW-1:0] dma_rsp_rdata,
    output logic              dccm_en,
    output logic              dccm_we,
    output logic [AW-1:0]     dccm_addr,
    output logic [CCM_DW-1:0] dccm_wdata,
    output logic [CCM_SW-1:0] dccm_wstrb,
    input  logic [CCM_DW-1:0] dccm_rdata
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
        $error("dccm_port_arbiter: MAX_WAIT must lie in 1..15");
    end

    ccm_req_t   lsu_req_s;
    ccm_req_t   dma_req_s;
    ccm_req_t   sel_req_s;
    logic       force_dma_s;
    logic       lsu_grant_s;
    logic       dma_grant_s;
    ccm_owner_e rsp_owner_r;

    assign lsu_req_s = '{we: lsu_req_we, addr: CCM_AW'(lsu_req_addr),
                         wdata: lsu_req_wdata, wstrb: lsu_req_wstrb};
    assign dma_req_s = '{we: dma_req_we, addr: CCM_AW'(dma_req_addr),
                         wdata: dma_req_wdata, wstrb: dma_req_wstrb};

`ifdef DCCM_DMA_STARVE_GUARD_EN
    dccm_arb_wait_ctr #(
        .MAX_WAIT   (MAX_WAIT)
    ) u_wait_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .dma_valid  (dma_req_valid),
        .dma_ready  (dma_req_ready),
        .both_valid (lsu_req_valid & dma_req_valid),
        .force_dma  (force_dma_s)
    );
`else
    assign force_dma_s = 1'b0;
`endif

    // Grant selection: LSU first unless the starvation guard hands this cycle to DMA
    always_comb begin
        lsu_grant_s = 1'b0;
        dma_grant_s = 1'b0;
        if (!rst_n) begin
            lsu_grant_s = 1'b0;
            dma_grant_s = 1'b0;
        end else if (lsu_req_valid && !force_dma_s) begin
            lsu_grant_s = 1'b1;
        end else if (dma_req_valid) begin
            dma_grant_s = 1'b1;
        end else begin
            lsu_grant_s = 1'b0;
            dma_grant_s = 1'b0;
        end
    end

    assign lsu_req_ready = lsu_grant_s;
    assign dma_req_ready = dma_grant_s;
    assign sel_req_s     = dma_grant_s ? dma_req_s : lsu_req_s;

    assign dccm_en    = lsu_grant_s | dma_grant_s;
    assign dccm_we    = dccm_en & sel_req_s.we;
    assign dccm_addr  = AW'(sel_req_s.addr);
    assign dccm_wdata = sel_req_s.wdata;
    assign dccm_wstrb = sel_req_s.wstrb;

    // Remember who issued this cycle's read so next cycle's SRAM data goes back to them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_owner_r <= NONE;
        end else if (lsu_grant_s && !lsu_req_we) begin
            rsp_owner_r <= LSU;
        end else if (dma_grant_s && !dma_req_we) begin
            rsp_owner_r <= DMA;
        end else begin
            rsp_owner_r <= NONE;
        end
    end

    // Route returning read data; the non-owner sees zeros
    always_comb begin
        lsu_rsp_valid = 1'b0;
        lsu_rsp_rdata = {CCM_DW{1'b0}};
        dma_rsp_valid = 1'b0;
        dma_rsp_rdata = {CCM_DW{1'b0}};
        case (rsp_owner_r)
            LSU: begin
                lsu_rsp_valid = 1'b1;
                lsu_rsp_rdata = dccm_rdata;
            end
            DMA: begin
                dma_rsp_valid = 1'b1;
                dma_rsp_rdata = dccm_rdata;
            end
            default: begin
                lsu_rsp_valid = 1'b0;
                dma_rsp_valid = 1'b0;
            end
        endcase
    end

endmodule
